// File: rtl/alu_md_pkg.sv
// alu_md_pkg: shared definitions for the multi-cycle EX-stage ALU (alu_md).
//   - 5-bit operation encodings. ALU_* values 0-13 are the legacy
//     single-cycle set; MUL/DIV families are 16-18 and 20-23.
//   - FSM state enum for the top-level controller.
//   - Small decode helpers used by the top.
// Optional feature macro: ALU_MD_DIV_EN (enables the divide family).
package alu_md_pkg;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_ADD   = 5'd1;
  localparam logic [4:0] ALU_SUB   = 5'd2;
  localparam logic [4:0] ALU_AND   = 5'd3;
  localparam logic [4:0] ALU_OR    = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_XOR   = 5'd6;
  localparam logic [4:0] ALU_SLT   = 5'd7;
  localparam logic [4:0] ALU_SGT   = 5'd8;
  localparam logic [4:0] ALU_SLTU  = 5'd9;
  localparam logic [4:0] ALU_LUI   = 5'd10;
  localparam logic [4:0] ALU_SLL   = 5'd11;
  localparam logic [4:0] ALU_SRL   = 5'd12;
  localparam logic [4:0] ALU_SRA   = 5'd13;
  localparam logic [4:0] ALU_MUL   = 5'd16;
  localparam logic [4:0] ALU_MULH  = 5'd17;
  localparam logic [4:0] ALU_MULHU = 5'd18;
  localparam logic [4:0] ALU_DIV   = 5'd20;
  localparam logic [4:0] ALU_DIVU  = 5'd21;
  localparam logic [4:0] ALU_REM   = 5'd22;
  localparam logic [4:0] ALU_REMU  = 5'd23;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Signed variants work on operand magnitudes and need a sign fix-up.
  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  // Ops that take the multi-cycle CALC/FIX path.
  function automatic logic is_iter_op(input logic [4:0] op);
`ifdef ALU_MD_DIV_EN
    return is_mul_op(op) || is_div_op(op);
`else
    return is_mul_op(op);
`endif
  endfunction

endpackage

// File: rtl/alu_md_iter.sv
// alu_md_iter: shared radix-2 iterative datapath for alu_md.
//   Multiply: shift-add; {hi,lo} ends as the 2*WIDTH product of operand*init_lo.
//   Divide (ALU_MD_DIV_EN only): restoring; lo ends as quotient, hi as remainder
//   of init_lo / operand. A zero divisor naturally yields all-ones / dividend.
// Ports:
//   clk, rstn        clock, async active-low reset
//   clear            abandon any work in progress (counter back to 0)
//   load             capture init_lo/operand (and div_mode) for a new operation
//   step             perform one iteration
//   div_mode         (ALU_MD_DIV_EN only) 1 = divide, 0 = multiply
//   init_lo,operand  multiplier/multiplicand or dividend/divisor magnitudes
//   hi, lo           working registers, final result after WIDTH steps
//   last             high during the final (WIDTH-th) iteration
module alu_md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
`ifdef ALU_MD_DIV_EN
  input  logic             div_mode,
`endif
  input  logic [WIDTH-1:0] init_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic [WIDTH:0]   sum;
`ifdef ALU_MD_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
`endif

  assign last = &count;

  // One iteration step: the add-and-shift-right is the default; the divider
  // overrides it with shift-left-and-trial-subtract when in divide mode.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    hi_d = sum[WIDTH:1];
    lo_d = {sum[0], lo[WIDTH-1:1]};
`ifdef ALU_MD_DIV_EN
    shifted = {hi, lo[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (div_q) begin
      hi_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_d = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi    <= '0;
      lo    <= '0;
      opnd  <= '0;
      count <= '0;
`ifdef ALU_MD_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      hi    <= '0;
      lo    <= init_lo;
      opnd  <= operand;
      count <= '0;
`ifdef ALU_MD_DIV_EN
      div_q <= div_mode;
`endif
    end else if (step) begin
      hi    <= hi_d;
      lo    <= lo_d;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_md.sv
// alu_md: parametrised multi-cycle ALU with start/done handshake.
//   Simple ops complete one cycle after acceptance; MUL/DIV families run
//   WIDTH iterations in alu_md_iter, then a FIX cycle applies signs.
// Optional feature macro: ALU_MD_DIV_EN. When undefined the divider is
//   omitted and DIV/DIVU/REM/REMU complete in one cycle with result 0.
// Ports:
//   clk, rstn   clock (rising edge), async active-low reset
//   start       request, sampled in IDLE or DONE
//   flush       synchronous abort to IDLE, beats start, leaves result alone
//   op          operation code (alu_md_pkg)
//   a, b        operands; a[SHW-1:0] is the shift amount
//   result      registered result; zero = (result == 0)
//   busy        high in CALC/FIX; done high exactly in DONE
module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             flush,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_e state_q, state_d;

  logic [4:0]         op_q;
  logic               neg_q;
`ifdef ALU_MD_DIV_EN
  logic               a_neg_q;
  logic               b_zero_q;
`endif
  logic               load_res;
  logic               iter_load;
  logic               iter_step;
  logic               iter_clear;
  logic               iter_last;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   simple_res;
  logic [WIDTH-1:0]   fix_res;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   init_lo;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   iter_hi;
  logic [WIDTH-1:0]   iter_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [SHW-1:0]     sh;

  assign sh    = a[SHW-1:0];
  assign a_mag = (is_signed_op(op) && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed_op(op) && b[WIDTH-1]) ? -b : b;
`ifdef ALU_MD_DIV_EN
  assign init_lo = is_div_op(op) ? a_mag : b_mag;
  assign operand = is_div_op(op) ? b_mag : a_mag;
`else
  assign init_lo = b_mag;
  assign operand = a_mag;
`endif

  // Single-cycle results, computed straight from the live inputs because
  // they are registered on the accepting edge.
  always_comb begin
    simple_res = a;
    unique case (op)
      ALU_ADD:  simple_res = a + b;
      ALU_SUB:  simple_res = a - b;
      ALU_AND:  simple_res = a & b;
      ALU_OR:   simple_res = a | b;
      ALU_NOR:  simple_res = ~(a | b);
      ALU_XOR:  simple_res = a ^ b;
      ALU_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SGT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      ALU_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_LUI:  simple_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      ALU_SLL:  simple_res = b << sh;
      ALU_SRL:  simple_res = b >> sh;
      ALU_SRA:  simple_res = $unsigned($signed(b) >>> sh);
`ifndef ALU_MD_DIV_EN
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: simple_res = '0;
`endif
      default:  simple_res = a;
    endcase
  end

  // FIX-cycle sign correction of the iterative result. A signed quotient by
  // zero must stay all-ones, so it bypasses the negation.
  always_comb begin
    prod     = {iter_hi, iter_lo};
    prod_fix = neg_q ? -prod : prod;
    fix_res  = prod_fix[WIDTH-1:0];
    if ((op_q == ALU_MULH) || (op_q == ALU_MULHU)) begin
      fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end
`ifdef ALU_MD_DIV_EN
    else if ((op_q == ALU_DIV) || (op_q == ALU_DIVU)) begin
      fix_res = b_zero_q ? '1 : (neg_q ? -iter_lo : iter_lo);
    end else if ((op_q == ALU_REM) || (op_q == ALU_REMU)) begin
      fix_res = a_neg_q ? -iter_hi : iter_hi;
    end
`endif
  end

  // Next-state and control decode. flush outranks everything.
  always_comb begin
    state_d    = state_q;
    load_res   = 1'b0;
    res_d      = result;
    iter_load  = 1'b0;
    iter_step  = 1'b0;
    iter_clear = 1'b0;
    if (flush) begin
      state_d    = IDLE;
      iter_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            if (is_iter_op(op)) begin
              state_d   = CALC;
              iter_load = 1'b1;
            end else begin
              state_d  = DONE;
              load_res = 1'b1;
              res_d    = simple_res;
            end
          end
        end
        CALC: begin
          iter_step = 1'b1;
          if (iter_last) state_d = FIX;
        end
        FIX: begin
          state_d  = DONE;
          load_res = 1'b1;
          res_d    = fix_res;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Operation context latched at acceptance for the FIX cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q     <= ALU_NOP;
      neg_q    <= 1'b0;
`ifdef ALU_MD_DIV_EN
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
`endif
    end else if (iter_load) begin
      op_q     <= op;
      neg_q    <= is_signed_op(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef ALU_MD_DIV_EN
      a_neg_q  <= is_signed_op(op) && a[WIDTH-1];
      b_zero_q <= (b == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (load_res) begin
      result <= res_d;
      zero   <= (res_d == '0);
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);

  alu_md_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (iter_clear),
    .load    (iter_load),
    .step    (iter_step),
`ifdef ALU_MD_DIV_EN
    .div_mode(is_div_op(op)),
`endif
    .init_lo (init_lo),
    .operand (operand),
    .hi      (iter_hi),
    .lo      (iter_lo),
    .last    (iter_last)
  );

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle SCPU ALU. Adds configurable data width, registered results and a start/done handshake.
- Adds iterative radix-2 multiply and divide, and fixes the shift path: the shift amount is a runtime field, not an elaboration-time width.
- Sits in the EX stage of the multi-cycle CPU. The controller raises start, stalls while busy, and captures result on done.

Parameters:
- WIDTH, 32, operand/result width; must be ≥4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk      input   1      system clock, rising edge.
- rstn     input   1      asynchronous active-low reset.
- start    input   1      request; sampled when state is IDLE or DONE.
- flush    input   1      synchronous abort; returns to IDLE.
- op       input   5      operation code (alu_md_pkg encodings).
- a        input   WIDTH  operand A; also the shift amount source.
- b        input   WIDTH  operand B.
- result   output  WIDTH  registered result.
- zero     output  1      registered (result == 0).
- busy     output  1      high in CALC or FIX.
- done     output  1      one-cycle pulse; result is valid.

Behaviour:
- Reset (async, rstn=0): state=IDLE, result=0, zero=1, busy=0, done=0, counter=0. Reset mid-operation discards all work.
- States:
  - IDLE/DONE --start & simple op--> DONE
  - IDLE/DONE --start & MUL/DIV op--> CALC
  - CALC --WIDTH iterations--> FIX
  - FIX --> DONE
  - DONE --no start--> IDLE
- done=1 exactly while in DONE. Back-to-back starts from DONE are legal.
- Latency, measured from the start edge:
  - Simple ops: done on the next cycle (1).
  - MUL/DIV: done at WIDTH+2 (34 for WIDTH=32).
- start in CALC/FIX is ignored. Operands and op are latched at acceptance; later input changes have no effect.
- flush has priority over start. Any state goes to IDLE next edge, with no done pulse and result unchanged.
- Simple ops:
  - NOP: result=a.
  - ADD, SUB: wrap modulo 2^WIDTH.
  - AND, OR, NOR, XOR.
  - SLT/SGT: signed compare. SLTU: unsigned compare. Each yields 1 or 0.
  - LUI: {b[WIDTH/2-1:0], zeros}.
  - SLL/SRL/SRA: shift b by a[SHW-1:0]. SRA sign-fills from b[WIDTH-1]. Shift amount 0 returns b unchanged.
- MUL/MULH/MULHU: shift-add over |a|,|b| (signed variants) or raw operands (MULHU). The 2·WIDTH product is negated in FIX when the operand signs differ. MUL returns the low half; MULH/MULHU return the high half.
- DIV/DIVU/REM/REMU: restoring division on magnitudes. FIX applies signs: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Divide boundary cases:
  - Divisor 0: quotient all-ones, remainder = a. The full WIDTH+2 latency still applies.
  - Signed MIN / −1: quotient = MIN, remainder = 0.
- Undefined op: treated as NOP, latency 1.

Optional Feature:
- Macro ALU_MD_DIV_EN.
- Defined: DIV/DIVU/REM/REMU are implemented as above.
- Undefined: divider datapath omitted. Divide ops complete in 1 cycle with result=0, and the multiply path is unchanged.

Decomposition:
- alu_md_pkg holds:
  - The 5-bit op encodings. Existing ALU_* values 0–13 keep their numbering; MUL=16, MULH=17, MULHU=18, DIV=20, DIVU=21, REM=22, REMU=23.
  - The state enum (IDLE, CALC, FIX, DONE).
- One sub-module, alu_md_iter: shared shift-add/restoring-subtract datapath with a counter. The top holds the FSM, the simple-op logic and the sign fix-up.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1 -> done at cycle 1, result=0x80000000, zero=0; SUB a=5 b=5 -> result=0, zero=1.
- SRA a=4 b=0xF0000000 -> 0xFF000000; SLL a=0 b=0x1234 -> 0x1234; SLT a=-1 b=1 -> 1; SLTU same operands -> 0.
- MULH a=-3 b=7 -> done at cycle 34, result=0xFFFFFFFF; MUL same operands -> 0xFFFFFFEB; start pulsed at cycle 10 is ignored.
- DIV a=-7 b=2 -> result=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=9 b=0 -> 0xFFFFFFFF; REMU -> 9; DIV 0x80000000 / -1 -> 0x80000000.
- flush at cycle 5 of MUL -> idle next cycle, no done, result holds its prior value; rstn low mid-DIV -> all outputs at reset values immediately.
- WIDTH=8 build without ALU_MD_DIV_EN: MUL a=15 b=17 -> result 0xFF at cycle 10; DIV -> result 0 at cycle 1.
